pc_redirect: RTL and testbench

- Fetch-side PC register and next-PC sequencer.
- Consumes the branch/jump target produced in decode (target address plus taken flag) and applies it to the fetch PC with MIPS delay-slot semantics.
- Also applies exception/ERET redirects and stalls.
- Sits between the decode-stage target computation and the instruction-memory address port.

---
 rtl/pc_redirect.sv | 131 +++++++++++++
 tb/tb_pc_redirect.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_redirect.sv
// Fetch PC register and next-PC sequencer. Applies decode-stage branch/jump
// targets with MIPS delay-slot semantics, plus exception/ERET redirects and stalls.
module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic [31:0] br_ds_pc_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] npc_o,
    output logic        pc_valid_o,
    output logic        flush_o,
    output logic        redirect_o
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [0:0] {
        ST_SEQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_flush_q, pend_flush_d;
    logic        pc_valid_q, pc_valid_d;
    logic        redirect_q, redirect_d;

    logic        advance_s;
    logic        accept_s;
    logic        wrong_path_s;
    logic        flush_s;

    assign npc_o      = pc_q + STEP;
    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;
    assign redirect_o = redirect_q;
    assign flush_o    = flush_s;

    // Next-PC selection, pending-target capture and wrong-path flush
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_flush_d  = pend_flush_q;
        pc_valid_d    = 1'b1;
        redirect_d    = 1'b0;

        advance_s    = !stall_i && pc_valid_q;
        accept_s     = br_valid_i && br_taken_i && (state_q == ST_SEQ);
        // A mismatch means the delay slot already issued, so pc_q is wrong-path.
        wrong_path_s = (pc_q != br_ds_pc_i);

        if (rst) begin
            flush_s = 1'b0;
        end else begin
            flush_s = exc_valid_i
                    || (accept_s && wrong_path_s)
                    || ((state_q == ST_HOLD) && pend_flush_q);
        end

        if (exc_valid_i) begin
            pc_d          = exc_target_i;
            state_d       = ST_SEQ;
            pend_target_d = 32'h0000_0000;
            pend_flush_d  = 1'b0;
            redirect_d    = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (advance_s) begin
                        pc_d          = pend_target_q;
                        state_d       = ST_SEQ;
                        pend_target_d = 32'h0000_0000;
                        pend_flush_d  = 1'b0;
                        redirect_d    = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_SEQ: begin
                    if (accept_s && advance_s) begin
                        pc_d       = br_target_i;
                        redirect_d = 1'b1;
                    end else if (accept_s) begin
                        pend_target_d = br_target_i;
                        pend_flush_d  = wrong_path_s;
                        state_d       = ST_HOLD;
                    end else if (advance_s) begin
                        pc_d = npc_o;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: begin
                    state_d       = ST_SEQ;
                    pend_target_d = 32'h0000_0000;
                    pend_flush_d  = 1'b0;
                end
            endcase
        end
    end

    // State, PC and status registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SEQ;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
            pend_flush_q  <= 1'b0;
            pc_valid_q    <= 1'b0;
            redirect_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_flush_q  <= pend_flush_d;
            pc_valid_q    <= pc_valid_d;
            redirect_q    <= redirect_d;
        end
    end

endmodule

// File: tb/tb_pc_redirect.sv
// Scoreboard bench for pc_redirect: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares them every cycle.
module tb_pc_redirect;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, br_valid_i, br_taken_i, exc_valid_i;
    logic [31:0] br_target_i, br_ds_pc_i, exc_target_i;
    logic [31:0] pc_o, npc_o;
    logic        pc_valid_o, flush_o, redirect_o;

    pc_redirect #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .br_valid_i(br_valid_i), .br_taken_i(br_taken_i),
        .br_target_i(br_target_i), .br_ds_pc_i(br_ds_pc_i),
        .exc_valid_i(exc_valid_i), .exc_target_i(exc_target_i),
        .pc_o(pc_o), .npc_o(npc_o), .pc_valid_o(pc_valid_o),
        .flush_o(flush_o), .redirect_o(redirect_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        r;
        logic        f;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: architectural PC plus an optional pending redirect.
    logic [31:0] m_pc;
    logic        m_valid, m_redir, m_pflush;
    logic [31:0] m_pend[$];

    task automatic model_reset();
        m_pc = RST_PC; m_valid = 1'b0; m_redir = 1'b0; m_pflush = 1'b0;
        m_pend.delete();
    endtask

    task automatic cycle(input logic r, input logic st, input logic bv, input logic bt,
                         input logic [31:0] tgt, input logic [31:0] ds,
                         input logic ex, input logic [31:0] et);
        exp_t e;
        logic adv;
        @(negedge clk);
        rst = r; stall_i = st; br_valid_i = bv; br_taken_i = bt;
        br_target_i = tgt; br_ds_pc_i = ds; exc_valid_i = ex; exc_target_i = et;
        if (r) model_reset();
        e.pc = m_pc; e.v = m_valid; e.r = m_redir;
        e.f = !r && (ex || (m_pend.size() > 0 && m_pflush)
                        || (m_pend.size() == 0 && bv && bt && m_pc != ds));
        exp_q.push_back(e);
        if (!r) begin
            adv = !st && m_valid;
            m_redir = 1'b0;
            if (ex) begin
                m_pc = et; m_pend.delete(); m_redir = 1'b1;
            end else if (m_pend.size() > 0) begin
                if (adv) begin m_pc = m_pend.pop_front(); m_redir = 1'b1; end
            end else if (bv && bt) begin
                if (adv) begin m_pc = tgt; m_redir = 1'b1; end
                else begin m_pend.push_back(tgt); m_pflush = (m_pc != ds); end
            end else if (adv) begin
                m_pc = m_pc + 32'd4;
            end
            m_valid = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_o", pc_o, e.pc);
                chk("npc_o", npc_o, e.pc + 32'd4);
                chk("pc_valid_o", {31'd0, pc_valid_o}, {31'd0, e.v});
                chk("redirect_o", {31'd0, redirect_o}, {31'd0, e.r});
                chk("flush_o", {31'd0, flush_o}, {31'd0, e.f});
            end
        end
    end

    initial begin
        logic [31:0] ds;
        int          wait_cnt;
        rst = 1'b1; stall_i = 1'b0; br_valid_i = 1'b0; br_taken_i = 1'b0;
        br_target_i = 32'h0; br_ds_pc_i = 32'h0; exc_valid_i = 1'b0; exc_target_i = 32'h0;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        // Sequential fetch from reset; reaches BFC00010
        idle(5);
        // Delay slot is current PC: bypass to target
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_1000, m_pc, 1'b0, 32'h0);
        idle(2);
        // Wrong-path PC, no stall
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0014);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_2000, 32'hBFC0_0010, 1'b0, 32'h0);
        idle(1);
        // Wrong-path PC stalled for 3 cycles, then released
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0014);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_2000, 32'hBFC0_0010, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h9000_0000, 32'hBFC0_0010, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        idle(2);
        // Exception while stalled in HOLD discards the pending target
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_3000, 32'h0000_0000, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0380);
        idle(3);
        // Wraparound at the top of the address space
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        idle(2);
        // Reset asserted mid-HOLD
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_4000, 32'h1234_5678, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        idle(4);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ds = ($urandom_range(0, 1) == 0) ? m_pc : $urandom();
            cycle(($urandom_range(0, 60) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0),
                  $urandom(), ds,
                  ($urandom_range(0, 15) == 0),
                  $urandom());
        end
        idle(2);
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
